// File: rtl/mips_pkg.sv
// mips_pkg: opcode, funct and register constants shared by the MIPS-I core.
// No ports; imported by mips and mips_regs.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_REGIMM  = 6'h01,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_BLEZ    = 6'h06,
        OP_BGTZ    = 6'h07,
        OP_ADDI    = 6'h08,
        OP_ADDIU   = 6'h09,
        OP_SLTI    = 6'h0A,
        OP_SLTIU   = 6'h0B,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LW      = 6'h23,
        OP_SW      = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_SRA  = 6'h03,
        FN_SLLV = 6'h04,
        FN_SRLV = 6'h06,
        FN_SRAV = 6'h07,
        FN_JR   = 6'h08,
        FN_JALR = 6'h09,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_e;

    // rt field selectors under OP_REGIMM
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    localparam logic [4:0] REG_SP = 5'd29;
    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/mips_regs.sv
// mips_regs: 32x32 register file, two combinational read ports, one synchronous write port.
// Ports: clk, reset (async, active-high; loads sp/ra init values),
//        rs_addr_i/rs_data_o and rt_addr_i/rt_data_o read ports,
//        we_i/waddr_i/wdata_i write port (writes to $0 are dropped).
module mips_regs
    import mips_pkg::*;
#(
    parameter logic [31:0] sp_init = 32'h80120000,
    parameter logic [31:0] ra_init = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_addr_i,
    input  logic [4:0]  rt_addr_i,
    output logic [31:0] rs_data_o,
    output logic [31:0] rt_data_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] data [0:31];

    // $0 is never written, so it keeps its reset value of zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++)
                data[i] <= (5'(i) == REG_SP) ? sp_init : (5'(i) == REG_RA) ? ra_init : 32'h0;
        end else if (we_i && waddr_i != 5'd0) begin
            data[waddr_i] <= wdata_i;
        end
    end

    assign rs_data_o = data[rs_addr_i];
    assign rt_data_o = data[rt_addr_i];

endmodule

// File: rtl/mips.sv
// mips: single-cycle big-endian MIPS-I integer core with a branch delay slot.
// Ports: clk, reset (async, active-high),
//        instr_addr (current pc) / instr_in (combinational fetch),
//        data_addr / data_in (combinational load) / data_out (store data),
//        data_rd_wr (1 = read, 0 = store committed at the next rising clk).
module mips
    import mips_pkg::*;
#(
    parameter logic [31:0] pc_init = 32'h80020000,
    parameter logic [31:0] sp_init = 32'h80120000,
    parameter logic [31:0] ra_init = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_in,
    output logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_rd_wr
);

    logic [31:0] pc_q, npc_q, pc_d, npc_d;
    logic [31:0] rs_v, rt_v, imm_s, imm_z, pc4, alu, tgt, wdata;
    logic [4:0]  rs, rt, rd, shamt, waddr;
    logic [5:0]  op, fn;
    logic        we, taken, is_lw, is_sw;

    assign op    = instr_in[31:26];
    assign rs    = instr_in[25:21];
    assign rt    = instr_in[20:16];
    assign rd    = instr_in[15:11];
    assign shamt = instr_in[10:6];
    assign fn    = instr_in[5:0];
    assign imm_s = {{16{instr_in[15]}}, instr_in[15:0]};
    assign imm_z = {16'h0, instr_in[15:0]};
    assign pc4   = pc_q + 32'd4;

    mips_regs #(
        .sp_init(sp_init),
        .ra_init(ra_init)
    ) regs (
        .clk       (clk),
        .reset     (reset),
        .rs_addr_i (rs),
        .rt_addr_i (rt),
        .rs_data_o (rs_v),
        .rt_data_o (rt_v),
        .we_i      (we & ~reset),
        .waddr_i   (waddr),
        .wdata_i   (wdata)
    );

    // Unrecognised encodings fall through with we/taken/is_sw low, i.e. a NOP
    always_comb begin
        alu   = 32'h0;
        we    = 1'b0;
        waddr = rt;
        taken = 1'b0;
        tgt   = pc4 + (imm_s << 2);
        is_lw = 1'b0;
        is_sw = 1'b0;
        case (op)
            OP_SPECIAL: begin
                waddr = rd;
                we    = 1'b1;
                case (fn)
                    FN_SLL:          alu = rt_v << shamt;
                    FN_SRL:          alu = rt_v >> shamt;
                    FN_SRA:          alu = $signed(rt_v) >>> shamt;
                    FN_SLLV:         alu = rt_v << rs_v[4:0];
                    FN_SRLV:         alu = rt_v >> rs_v[4:0];
                    FN_SRAV:         alu = $signed(rt_v) >>> rs_v[4:0];
                    FN_JR:           begin we = 1'b0; taken = 1'b1; tgt = rs_v; end
                    FN_JALR:         begin alu = pc4 + 32'd4; taken = 1'b1; tgt = rs_v; end
                    FN_ADD, FN_ADDU: alu = rs_v + rt_v;
                    FN_SUB, FN_SUBU: alu = rs_v - rt_v;
                    FN_AND:          alu = rs_v & rt_v;
                    FN_OR:           alu = rs_v | rt_v;
                    FN_XOR:          alu = rs_v ^ rt_v;
                    FN_NOR:          alu = ~(rs_v | rt_v);
                    FN_SLT:          alu = {31'h0, $signed(rs_v) < $signed(rt_v)};
                    FN_SLTU:         alu = {31'h0, rs_v < rt_v};
                    default:         we = 1'b0;
                endcase
            end
            OP_REGIMM: taken = (rt == RT_BLTZ) ? rs_v[31] : (rt == RT_BGEZ) ? ~rs_v[31] : 1'b0;
            OP_J: begin
                taken = 1'b1;
                tgt   = {pc4[31:28], instr_in[25:0], 2'b00};
            end
            OP_JAL: begin
                taken = 1'b1;
                tgt   = {pc4[31:28], instr_in[25:0], 2'b00};
                we    = 1'b1;
                waddr = REG_RA;
                alu   = pc4 + 32'd4;
            end
            OP_BEQ:            taken = rs_v == rt_v;
            OP_BNE:            taken = rs_v != rt_v;
            OP_BLEZ:           taken = rs_v[31] | (rs_v == 32'h0);
            OP_BGTZ:           taken = ~rs_v[31] & (rs_v != 32'h0);
            OP_ADDI, OP_ADDIU: begin we = 1'b1; alu = rs_v + imm_s; end
            OP_SLTI:           begin we = 1'b1; alu = {31'h0, $signed(rs_v) < $signed(imm_s)}; end
            OP_SLTIU:          begin we = 1'b1; alu = {31'h0, rs_v < imm_s}; end
            OP_ANDI:           begin we = 1'b1; alu = rs_v & imm_z; end
            OP_ORI:            begin we = 1'b1; alu = rs_v | imm_z; end
            OP_XORI:           begin we = 1'b1; alu = rs_v ^ imm_z; end
            OP_LUI:            begin we = 1'b1; alu = {instr_in[15:0], 16'h0}; end
            OP_LW:             begin we = 1'b1; is_lw = 1'b1; alu = rs_v + imm_s; end
            OP_SW:             begin is_sw = 1'b1; alu = rs_v + imm_s; end
            default:           ;
        endcase
    end

    assign wdata = is_lw ? data_in : alu;

    // pc follows npc; npc carries the delay-slot successor or the branch target
    assign pc_d  = npc_q;
    assign npc_d = taken ? tgt : npc_q + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= pc_init;
            npc_q <= pc_init + 32'd4;
        end else begin
            pc_q  <= pc_d;
            npc_q <= npc_d;
        end
    end

    assign instr_addr = pc_q;
    assign data_addr  = alu;
    assign data_out   = rt_v;
    // reset must never let a store reach memory
    assign data_rd_wr = reset | ~is_sw;

endmodule

// File: tb/tb_mips.sv
module tb_mips;

    localparam logic [31:0] PC0 = 32'h80020000;
    localparam logic [5:0] RFN [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                        6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
    localparam logic [5:0] IOPS [8] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    typedef struct {
        logic [31:0] pc;
        logic        rw;
        logic        ma;
        logic [31:0] addr;
        logic [31:0] dout;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ld_mem = 1'b1;
    logic [31:0] instr_addr, instr_in, data_addr, data_in, data_out, ofs;
    logic        data_rd_wr;
    logic [31:0] imem  [0:63];
    logic [31:0] dmem  [0:63];
    logic [31:0] dinit [0:63];
    logic [31:0] m_r   [0:31];
    logic [31:0] m_mem [0:63];
    logic [31:0] m_pc, m_npc;
    exp_t        sb[$];
    exp_t        me;
    int          tests = 0;
    int          fails = 0;

    mips dut (
        .clk        (clk),
        .reset      (reset),
        .instr_addr (instr_addr),
        .instr_in   (instr_in),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_rd_wr (data_rd_wr)
    );

    always #5 clk = ~clk;

    // program window of 64 words at PC0; everything else fetches 0 (SLL $0,$0,0)
    assign ofs      = instr_addr - PC0;
    assign instr_in = (ofs < 32'd256) ? imem[ofs[7:2]] : 32'h0;
    assign data_in  = dmem[data_addr[7:2]];

    always @(posedge clk) begin
        if (ld_mem) begin
            for (int i = 0; i < 64; i++) dmem[i] <= dinit[i];
        end else if (!data_rd_wr) begin
            dmem[data_addr[7:2]] <= data_out;
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] fetch(logic [31:0] a);
        logic [31:0] o;
        o = a - PC0;
        return (o < 32'd256) ? imem[o[7:2]] : 32'h0;
    endfunction

    function automatic logic [31:0] ri(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rr(logic [5:0] fn, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        return {6'h0, rs, rt, rd, 5'h0, fn};
    endfunction

    function automatic logic [4:0] rp();
        int r;
        r = int'($urandom_range(0, 9));
        return (r < 8) ? 5'(r) : (r == 8) ? 5'd29 : 5'd31;
    endfunction

    function automatic logic [31:0] gen();
        int c, b, o;
        c = int'($urandom_range(0, 19));
        o = int'($urandom_range(0, 10)) - 3;
        b = int'($urandom_range(0, 5));
        if (c < 7)  return {6'h0, rp(), rp(), rp(), 5'($urandom_range(0, 31)), RFN[$urandom_range(0, 15)]};
        if (c < 13) return {IOPS[$urandom_range(0, 7)], rp(), rp(), 16'($urandom)};
        if (c < 16) return {($urandom_range(0, 1) != 0) ? 6'h23 : 6'h2B, rp(), rp(), 16'($urandom_range(0, 255))};
        if (c < 18) return (b < 4) ? {6'(4 + b), rp(), rp(), 16'(o)} : {6'h01, rp(), 5'(b - 4), 16'(o)};
        if (c == 18) begin
            b = int'($urandom_range(0, 2));
            if (b == 0) return {6'h03, 26'((PC0 >> 2) + 32'($urandom_range(0, 63)))};
            if (b == 1) return {6'h0, rp(), 5'h0, rp(), 5'h0, 6'h09};
            return rr(6'h08, 5'd31, 5'd0, 5'd0);
        end
        b = int'($urandom_range(0, 3));
        if (b == 0) return {6'h10, 26'($urandom)};
        if (b == 1) return {6'h0, 20'($urandom), 6'h0C};
        if (b == 2) return {6'h01, rp(), 5'h10, 16'($urandom)};
        return {6'h20, 26'($urandom)};
    endfunction

    task automatic model_reset();
        m_pc  = PC0;
        m_npc = PC0 + 32'd4;
        for (int i = 0; i < 32; i++) m_r[i] = 32'h0;
        m_r[29] = 32'h80120000;
        for (int i = 0; i < 64; i++) m_mem[i] = dinit[i];
    endtask

    // ISA-level interpreter: one instruction per call, expected bus activity pushed to the scoreboard
    task automatic model_step();
        exp_t        e;
        logic [31:0] ins, a, b, se, v, tgt, nxt, ad;
        logic [4:0]  wi;
        logic        w, tk;
        ins = fetch(m_pc);
        a   = m_r[ins[25:21]];
        b   = m_r[ins[20:16]];
        se  = {{16{ins[15]}}, ins[15:0]};
        nxt = m_pc + 32'd4;
        ad  = a + se;
        w   = 1'b1;
        wi  = ins[20:16];
        v   = 32'h0;
        tk  = 1'b0;
        tgt = nxt + (se << 2);
        e.pc = m_pc; e.rw = 1'b1; e.ma = 1'b0; e.addr = 32'h0; e.dout = 32'h0;
        case (ins[31:26])
            6'h00: begin
                wi = ins[15:11];
                case (ins[5:0])
                    6'h00: v = b << ins[10:6];
                    6'h02: v = b >> ins[10:6];
                    6'h03: v = $signed(b) >>> ins[10:6];
                    6'h04: v = b << a[4:0];
                    6'h06: v = b >> a[4:0];
                    6'h07: v = $signed(b) >>> a[4:0];
                    6'h08: begin w = 1'b0; tk = 1'b1; tgt = a; end
                    6'h09: begin v = m_pc + 32'd8; tk = 1'b1; tgt = a; end
                    6'h20, 6'h21: v = a + b;
                    6'h22, 6'h23: v = a - b;
                    6'h24: v = a & b;
                    6'h25: v = a | b;
                    6'h26: v = a ^ b;
                    6'h27: v = ~(a | b);
                    6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: v = (a < b) ? 32'd1 : 32'd0;
                    default: w = 1'b0;
                endcase
            end
            6'h01: begin
                w  = 1'b0;
                tk = (ins[20:16] == 5'd0 && $signed(a) < 0) || (ins[20:16] == 5'd1 && $signed(a) >= 0);
            end
            6'h02, 6'h03: begin
                w   = (ins[31:26] == 6'h03);
                wi  = 5'd31;
                v   = m_pc + 32'd8;
                tk  = 1'b1;
                tgt = {nxt[31:28], ins[25:0], 2'b00};
            end
            6'h04: begin w = 1'b0; tk = (a == b); end
            6'h05: begin w = 1'b0; tk = (a != b); end
            6'h06: begin w = 1'b0; tk = ($signed(a) <= 0); end
            6'h07: begin w = 1'b0; tk = ($signed(a) > 0); end
            6'h08, 6'h09: v = a + se;
            6'h0A: v = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0;
            6'h0B: v = (a < se) ? 32'd1 : 32'd0;
            6'h0C: v = a & {16'h0, ins[15:0]};
            6'h0D: v = a | {16'h0, ins[15:0]};
            6'h0E: v = a ^ {16'h0, ins[15:0]};
            6'h0F: v = {ins[15:0], 16'h0};
            6'h23: begin e.ma = 1'b1; e.addr = ad; v = m_mem[ad[7:2]]; end
            6'h2B: begin
                w = 1'b0; e.ma = 1'b1; e.rw = 1'b0; e.addr = ad; e.dout = b;
                m_mem[ad[7:2]] = b;
            end
            default: w = 1'b0;
        endcase
        sb.push_back(e);
        if (w && wi != 5'd0) m_r[wi] = v;
        m_pc  = m_npc;
        m_npc = tk ? tgt : m_npc + 32'd4;
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
    endtask

    // reset, reload data memory, run n instructions, then compare the whole register file
    task automatic run(int n);
        reset  = 1'b1;
        ld_mem = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ld_mem = 1'b0;
        model_reset();
        reset = 1'b0;
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
        end
        #2;
        for (int i = 0; i < 32; i++) chk($sformatf("reg%0d", i), dut.regs.data[i], m_r[i]);
    endtask

    // monitor: every cycle with an outstanding expectation is compared against the bus
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                me = sb.pop_front();
                chk("instr_addr", instr_addr, me.pc);
                chk("data_rd_wr", 32'(data_rd_wr), 32'(me.rw));
                if (me.ma) chk("data_addr", data_addr, me.addr);
                if (!me.rw) chk("data_out", data_out, me.dout);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        clear_imem();
        for (int i = 0; i < 64; i++) dinit[i] = $urandom;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_pc", instr_addr, PC0);
        chk("rst_sp", dut.regs.data[29], 32'h80120000);
        chk("rst_ra", dut.regs.data[31], 32'h0);
        chk("rst_v0", dut.regs.data[2], 32'h0);
        chk("rst_rw", 32'(data_rd_wr), 32'h1);

        clear_imem();
        imem[0] = ri(6'h09, 5'd0, 5'd2, 16'd5);
        imem[1] = ri(6'h09, 5'd0, 5'd3, 16'hFFFD);
        imem[2] = rr(6'h21, 5'd2, 5'd3, 5'd2);
        run(3);
        chk("addu_v0", dut.regs.data[2], 32'd2);
        chk("addiu_v1", dut.regs.data[3], 32'hFFFFFFFD);

        clear_imem();
        imem[0] = ri(6'h0F, 5'd0, 5'd2, 16'h1234);
        imem[1] = ri(6'h0D, 5'd2, 5'd2, 16'h5678);
        imem[2] = ri(6'h0F, 5'd0, 5'd29, 16'h8010);
        imem[3] = ri(6'h2B, 5'd29, 5'd2, 16'h0);
        imem[4] = ri(6'h23, 5'd29, 5'd3, 16'h0);
        run(5);
        chk("lw_v1", dut.regs.data[3], 32'h12345678);

        clear_imem();
        imem[0] = ri(6'h04, 5'd0, 5'd0, 16'd2);
        imem[1] = ri(6'h09, 5'd0, 5'd6, 16'd7);
        imem[2] = ri(6'h09, 5'd0, 5'd7, 16'd9);
        imem[3] = ri(6'h09, 5'd0, 5'd8, 16'd1);
        run(2);
        chk("beq_pc", instr_addr, 32'h8002000C);
        chk("beq_slot", dut.regs.data[6], 32'd7);
        chk("beq_skip", dut.regs.data[7], 32'd0);

        clear_imem();
        imem[0] = rr(6'h08, 5'd31, 5'd0, 5'd0);
        imem[1] = ri(6'h09, 5'd0, 5'd9, 16'd3);
        run(3);
        chk("jr_pc", instr_addr, 32'h4);
        chk("jr_slot", dut.regs.data[9], 32'd3);

        clear_imem();
        imem[0] = ri(6'h0F, 5'd0, 5'd4, 16'h8002);
        imem[1] = ri(6'h0D, 5'd4, 5'd4, 16'hFFFF);
        imem[2] = ri(6'h0A, 5'd4, 5'd5, 16'h0);
        run(3);
        chk("lui_ori", dut.regs.data[4], 32'h8002FFFF);
        chk("slti", dut.regs.data[5], 32'd1);

        // reset raised in the middle of a store cycle must suppress the store
        clear_imem();
        imem[0] = ri(6'h2B, 5'd0, 5'd29, 16'h0);
        imem[1] = ri(6'h09, 5'd0, 5'd2, 16'd1);
        dinit[0] = 32'hA5A5A5A5;
        run(0);
        chk("sw_active", 32'(data_rd_wr), 32'h0);
        reset = 1'b1;
        #1;
        chk("midrst_rw", 32'(data_rd_wr), 32'h1);
        chk("midrst_pc", instr_addr, PC0);
        @(negedge clk);
        #1;
        chk("midrst_mem", dmem[0], 32'hA5A5A5A5);
        chk("midrst_v0", dut.regs.data[2], 32'h0);
        chk("midrst_pc2", instr_addr, PC0);

        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 64; i++) begin
                imem[i]  = gen();
                dinit[i] = $urandom;
            end
            run(150);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips.md
MIPS -- requirements
Module: mips

Interface
REQ-001 Parameter pc_init, 32-bit, default 32'h80020000: program counter value on reset.
REQ-002 Parameter sp_init, 32-bit, default 32'h80120000: register $29 (sp) value on reset.
REQ-003 Parameter ra_init, 32-bit, default 32'h00000000: register $31 (ra) value on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 instr_addr  output  32  address of the instruction being executed (current PC).
REQ-007 instr_in  input  32  instruction word at instr_addr, available combinationally in the same cycle.
REQ-008 data_addr  output  32  load/store effective address.
REQ-009 data_in  input  32  load data at data_addr, available combinationally in the same cycle.
REQ-010 data_out  output  32  store data (rt value).
REQ-011 data_rd_wr  output  1  1 = read, 0 = write; memory commits the write at the next rising clk.

Function
REQ-012 Single-cycle, big-endian MIPS-I integer core: one instruction retires per clk; word accesses only.
REQ-013 Supported R-type: SLL, SRL, SRA, SLLV, SRLV, SRAV, JR, JALR, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU.
REQ-014 Supported I/J-type: J, JAL, BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ, ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI, LW, SW.
REQ-015 ADD/ADDI/SUB behave as ADDU/ADDIU/SUBU: no overflow trap; all arithmetic modulo 2^32.
REQ-016 Immediates are sign-extended except ANDI/ORI/XORI (zero-extended); LUI places imm in bits 31:16, zeros below.
REQ-017 SLT/SLTI compare signed; SLTU/SLTIU compare unsigned (SLTIU still sign-extends its immediate).
REQ-018 Any unsupported opcode/funct executes as NOP: no register write, no memory write, PC advances by 4.
REQ-019 Writes to $0 are discarded; $0 always reads 0.
REQ-020 Branch delay slot is honoured: state holds pc and npc; each cycle pc<=npc, npc<=npc+4 unless the current instruction is a taken branch/jump, then npc<=target.
REQ-021 Branch target = pc+4+(signext(imm)<<2); J/JAL target = {pc+4[31:28], index, 2'b00}; JR/JALR target = rs.
REQ-022 JAL writes pc+8 to $31; JALR writes pc+8 to rd.
REQ-023 LW/SW: data_addr = rs+signext(imm); LW writes data_in to rt at the clk edge ending the cycle.
REQ-024 data_rd_wr is 0 only during a SW cycle; data_out = rt value during SW, otherwise don't-care (drive rt value).
REQ-025 Outside load/store cycles data_addr is don't-care; drive the ALU result.
REQ-026 Jump to address 0 (program return) has no special handling; the core keeps fetching from 0.

Reset
REQ-027 While reset is high: pc=pc_init, npc=pc_init+4, $29=sp_init, $31=ra_init, all other registers 0, data_rd_wr=1.
REQ-028 Reset asserted mid-operation overrides any in-flight instruction; no register or memory write occurs during reset.
REQ-029 First instruction after reset deassertion executes at pc_init.

Structure
REQ-030 Register file SHALL be a sub-module instance named regs holding array data[0:31] (2 combinational read ports, 1 synchronous write port), readable hierarchically as regs.data[n].
REQ-031 Opcode and funct constants SHALL live in a shared package mips_pkg.
REQ-032 Decode, ALU and next-PC logic SHALL remain in mips itself.

Verification
REQ-033 Reset release: instr_addr=32'h80020000; regs.data[29]=32'h80120000; regs.data[31]=0; regs.data[2]=0.
REQ-034 ADDIU $2,$0,5 then ADDIU $3,$0,-3 then ADDU $2,$2,$3: regs.data[2]=2, regs.data[3]=32'hFFFFFFFD.
REQ-035 SW $2,0($29) with $2=32'h12345678, $29=32'h80100000 then LW $3,0($29): data_rd_wr=0 for one cycle with data_addr=32'h80100000; then regs.data[3]=32'h12345678.
REQ-036 BEQ $0,$0,+2 at 32'h80020000: delay slot 32'h80020004 executes, next instr_addr=32'h8002000C.
REQ-037 JR $31 with $31=0: delay slot executes, then instr_addr=0.
REQ-038 LUI $4,16'h8002 then ORI $4,$4,16'hFFFF then SLTI $5,$4,0: regs.data[4]=32'h8002FFFF, regs.data[5]=1.
